// File: rtl/param_delay_pkg.sv
// Shared constants and tap-clamp helper for the parametrised delay line.
package param_delay_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   localparam logic MODE_SHIFT  = 1'b0;
   localparam logic MODE_RECIRC = 1'b1;

   // A request of 0 still means one stage; anything past the end pins to the last stage.
   function automatic int clamp_delay(input int sel, input int depth);
      if (sel == 0) begin
         return 1;
      end else if (sel > depth) begin
         return depth;
      end else begin
         return sel;
      end
   endfunction

endpackage

// File: rtl/param_delay_line_tap_mux.sv
// DEPTH-way selector of {vld, data} stage words, indexed by the clamped delay.
// Purely combinational over flop outputs; tap changes show up in the same cycle.
module delay_tap_mux
   import param_delay_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int SEL_W = $clog2(DEPTH + 1)
) (
   input  logic [DEPTH-1:0][WIDTH:0] taps_i,
   input  logic [SEL_W-1:0]          sel_i,
   output logic [WIDTH:0]            tap_o
);

   int deff;

   always_comb begin
      deff  = clamp_delay(int'(sel_i), DEPTH);
      tap_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i == deff - 1) begin
            tap_o = taps_i[i];
         end
      end
   end

endmodule

// File: rtl/param_delay_line.sv
// Width/depth-configurable delay line with per-stage valid, selectable tap, recirculation and flush.
// Latency = clamped delay_sel cycles; no back-pressure, shifting while full drops the oldest entry.
module param_delay_line
   import param_delay_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int SEL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             shift_en_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             mode_recirc_i,
   input  logic             flush_i,
   input  logic [SEL_W-1:0] delay_sel_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   output logic [SEL_W-1:0] fill_count_o,
   output logic             full_o
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
   logic [DEPTH-1:0]            vld_q, vld_d;
   logic [SEL_W-1:0]            fill_q, fill_d;

   logic [DEPTH-1:0][WIDTH:0]   taps;
   logic [WIDTH:0]              tap_sel;

   always_comb begin
      stage_d = stage_q;
      vld_d   = vld_q;
      fill_d  = fill_q;
      if (flush_i) begin
         stage_d = '0;
         vld_d   = '0;
         fill_d  = '0;
      end else if (shift_en_i) begin
         if (mode_recirc_i == MODE_RECIRC) begin
            // Rotation keeps every entry in the line, so the count cannot move.
            stage_d = {stage_q[DEPTH-2:0], stage_q[DEPTH-1]};
            vld_d   = {vld_q[DEPTH-2:0], vld_q[DEPTH-1]};
         end else begin
            stage_d = {stage_q[DEPTH-2:0], in_data_i};
            vld_d   = {vld_q[DEPTH-2:0], in_valid_i};
            fill_d  = fill_q + SEL_W'(in_valid_i) - SEL_W'(vld_q[DEPTH-1]);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         stage_q <= '0;
         vld_q   <= '0;
         fill_q  <= '0;
      end else begin
         stage_q <= stage_d;
         vld_q   <= vld_d;
         fill_q  <= fill_d;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_taps
      assign taps[g] = {vld_q[g], stage_q[g]};
   end

   delay_tap_mux #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
   ) u_tap_mux (
      .taps_i (taps),
      .sel_i  (delay_sel_i),
      .tap_o  (tap_sel)
   );

   assign out_valid_o  = tap_sel[WIDTH];
   assign out_data_o   = tap_sel[WIDTH-1:0];
   assign fill_count_o = fill_q;
   assign full_o       = (fill_q == SEL_W'(DEPTH));

endmodule

// File: doc/param_delay_line.md
Name: param_delay_line

Overview:
- Parametrised successor to the fixed 10-stage, 8-bit input-to-output shift register.
- Configurable width and depth, per-stage valid tracking, runtime-selectable tap (delay) and shift enable.
- Recirculate (loop) mode, synchronous flush and an occupancy counter.
- Sits between a Tiny Tapeout top wrapper (ui_in/uo_out/uio_*) and the pads; the wrapper maps the ports below onto pins.

Parameters:
- WIDTH, 8, data bits per stage.
- DEPTH, 16, number of stages (minimum 2); maximum delay in cycles.
- SEL_W, $clog2(DEPTH+1), width of delay_sel and fill_count.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset: synchronous, active-low; sampled on rising edge of clk.
- shift_en  in  1  advance line by one stage this cycle.
- in_valid  in  1  qualifier for in_data entering stage 0.
- in_data  in  WIDTH  sample entering stage 0.
- mode_recirc  in  1  0 = shift in from in_data; 1 = stage DEPTH-1 loops back to stage 0.
- flush  in  1  synchronous clear of all stages.
- delay_sel  in  SEL_W  requested delay D in cycles (tap select).
- out_data  out  WIDTH  contents of tap stage.
- out_valid  out  1  valid bit of tap stage.
- fill_count  out  SEL_W  number of valid stages in the whole line.
- full  out  1  fill_count == DEPTH.

Behaviour:
- State: stage[0..DEPTH-1] (WIDTH bits each), vld[0..DEPTH-1], fill counter. Stage 0 is newest.
- Reset (rst_n==0 at edge): all stage = 0, vld = 0, fill = 0. Hence out_data = 0, out_valid = 0, fill_count = 0, full = 0 the cycle after.
- Priority per edge: reset > flush > shift_en > hold.
- flush: identical clearing effect to reset, ignores shift_en/in_*.
- Shift (shift_en=1, mode_recirc=0):
  - stage[i] <= stage[i-1] and vld[i] <= vld[i-1] for i≥1.
  - stage[0] <= in_data, vld[0] <= in_valid.
  - Data is captured regardless of in_valid; only vld marks it.
- Recirculate (shift_en=1, mode_recirc=1):
  - stage[0] <= stage[DEPTH-1], vld[0] <= vld[DEPTH-1]; in_* ignored.
  - fill unchanged.
- Hold (shift_en=0): all state unchanged; in_* ignored.
- Tap: effective delay Deff = 1 if delay_sel==0; DEPTH if delay_sel>DEPTH; else delay_sel.
  - out_data = stage[Deff-1], out_valid = vld[Deff-1].
  - Pure mux of flops, no combinational path from in_* to outputs.
- Latency: with shift_en held 1, a sample presented in cycle t appears on out_data during cycle t+Deff (Deff=10 reproduces the legacy block).
- delay_sel change takes effect in the same cycle (combinational tap); no state disturbed.
- fill (shift, non-recirc): fill <= fill + in_valid − vld[DEPTH-1].
  - Simultaneous in/out of valid entries nets to 0.
  - Never exceeds DEPTH, never underflows; assertion in bench.
- full = (fill == DEPTH). No back-pressure: shifting while full discards the oldest entry off the end.
- Mode switch mid-stream: takes effect on the next shifting edge; no data lost in the transition cycle.
- Reset or flush mid-operation discards all contents; the next shift restarts from an empty line.

Decomposition:
- Shared package param_delay_pkg:
  - default WIDTH/DEPTH constants.
  - function clamp_delay(sel) returning Deff.
  - mode encoding constants MODE_SHIFT=0, MODE_RECIRC=1.
- One sub-module: delay_tap_mux (DEPTH-way WIDTH+1-bit mux with clamp), instantiated once.
- Storage and fill counter stay in the top.

Test Plan (WIDTH=8, DEPTH=16):
1. Reset: rst_n=0 for 2 edges with shift_en=1, in_data=0xAA → all outputs 0, fill_count=0; asynchronous rst_n pulse between edges has no effect.
2. Latency: delay_sel=10, shift_en=1, in_valid=1, in_data=0x01,0x02,… → 0x01 on out_data with out_valid=1 exactly 10 cycles after presentation; repeat with delay_sel=0 (→1 cycle) and delay_sel=31 (→16 cycles).
3. Fill/full: push 16 valid words → fill_count steps 1..16, full=1; continue with in_valid=0 → fill_count decrements by 1 per shift to 0.
4. Recirculate: load 0x10..0x1F, set mode_recirc=1, delay_sel=16, shift 32 cycles → out_data cycles 0x10..0x1F twice, in_data=0xFF never appears, fill_count stays 16.
5. Hold/flush: shift_en=0 for 5 cycles → out_data and fill frozen; flush=1 with shift_en=1 → next cycle all stages 0, fill_count=0, full=0.
6. Dynamic tap: stream ramp 0x00.., switch delay_sel 4→12 mid-stream → out_data jumps the same cycle to the ramp value 12 behind the head, no state change.
